tof_echo_gen: RTL and testbench

TOF_ECHO_GEN -- requirements
Module: tof_echo_gen

---
 rtl/tof_echo_pkg.sv | 13 +
 rtl/tof_sync_edge.sv | 19 +
 rtl/tof_echo_gen.sv | 91 +++++++++
 tb/tb_tof_echo_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tof_echo_pkg.sv
// Shared types and constants for the time-of-flight echo generator.
package tof_echo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PULSE_LEN_DEF = 4;
    localparam int OVR_W         = 8;
    localparam int NUM_ECHO      = 2;

endpackage

// File: rtl/tof_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a 1-cycle pulse.
module tof_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    // [1:0] synchronise, [2] holds the previous synchronised sample
    logic [2:0] sync_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], d};
    end

    assign pulse = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/tof_echo_gen.sv
// Generates two delayed echo pulses from an asynchronous trigger; counts
// triggers that arrive while a sequence is still running.
module tof_echo_gen
    import tof_echo_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PULSE_LEN = PULSE_LEN_DEF
) (
    input  logic                io_mainClk,
    input  logic                io_asyncReset,
    input  logic                io_trigIn,
    input  logic                io_cfgEnable,
    input  logic [CNT_W-1:0]    io_cfgDelay0,
    input  logic [CNT_W-1:0]    io_cfgDelay1,
    output logic [NUM_ECHO-1:0] io_echoOut,
    output logic                io_busy,
    output logic [OVR_W-1:0]    io_overrunCount
);

    localparam logic [CNT_W:0] PULSE_W = (CNT_W+1)'(PULSE_LEN);
    localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

    state_t                         state_q, state_d;
    logic                           trig_pulse;
    logic                           start;
    logic                           done;
    logic [CNT_W:0]                 cnt_q;
    logic [CNT_W:0]                 end_cnt;
    logic [NUM_ECHO-1:0][CNT_W-1:0] delay_q;
    logic [NUM_ECHO-1:0]            echo_d;

    tof_sync_edge u_sync (
        .clk   (io_mainClk),
        .rst   (io_asyncReset),
        .d     (io_trigIn),
        .pulse (trig_pulse)
    );

    // Sequence is over once the later echo has finished its pulse; the extra
    // counter bit keeps max delay + pulse width from wrapping.
    assign end_cnt = ((delay_q[0] > delay_q[1]) ? {1'b0, delay_q[0]}
                                                : {1'b0, delay_q[1]}) + PULSE_W;
    assign done    = (cnt_q >= end_cnt);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_pulse && io_cfgEnable) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!io_cfgEnable || done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter value c seen at an edge means c+1 cycles have elapsed since start.
    for (genvar k = 0; k < NUM_ECHO; k++) begin : g_echo
        logic [CNT_W:0] lo, hi;
        assign lo        = {1'b0, delay_q[k]};
        assign hi        = lo + PULSE_W;
        assign echo_d[k] = (state_q == RUN) && io_cfgEnable &&
                           (cnt_q >= lo) && (cnt_q < hi);
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            delay_q         <= '0;
            io_echoOut      <= '0;
            io_overrunCount <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_q == RUN && state_d == RUN) ? cnt_q + CNT_ONE : '0;
            io_echoOut <= echo_d;
            if (start)
                delay_q <= {io_cfgDelay1, io_cfgDelay0};
            if (trig_pulse && state_q == RUN && io_overrunCount != '1)
                io_overrunCount <= io_overrunCount + 1'b1;
        end
    end

    assign io_busy = (state_q == RUN);

endmodule

// File: tb/tb_tof_echo_gen.sv
// Directed bench for tof_echo_gen: event-level model checked every cycle plus
// hand-computed timing checkpoints.
module tb_tof_echo_gen;

    localparam int CNT_W = 16;
    localparam int PL    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trig = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] d0 = '0;
    logic [CNT_W-1:0] d1 = '0;
    logic [1:0]       echo;
    logic             busy;
    logic [7:0]       ovr;

    int tests = 0;
    int fails = 0;

    tof_echo_gen #(.CNT_W(CNT_W), .PULSE_LEN(PL)) dut (
        .io_mainClk      (clk),
        .io_asyncReset   (rst),
        .io_trigIn       (trig),
        .io_cfgEnable    (en),
        .io_cfgDelay0    (d0),
        .io_cfgDelay1    (d1),
        .io_echoOut      (echo),
        .io_busy         (busy),
        .io_overrunCount (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: sequences described by start cycle and latched delays.
    int  cyc = 0;
    int  det_q[$];
    bit  m_run = 0, run_prev, m_prev = 0;
    int  m_start, m_d0, m_d1, m_end, m_ovr = 0;
    logic [1:0] exp_echo;

    always begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_run = 0; m_ovr = 0; m_prev = 0;
            det_q.delete();
        end else begin
            run_prev = m_run;
            if (m_run && (!en || cyc >= m_end)) m_run = 0;
            if (det_q.size() > 0 && det_q[0] == cyc) begin
                void'(det_q.pop_front());
                if (run_prev) begin
                    if (m_ovr < 255) m_ovr++;
                end else if (en) begin
                    m_run = 1; m_start = cyc; m_d0 = int'(d0); m_d1 = int'(d1);
                    m_end = cyc + 1 + ((m_d0 > m_d1) ? m_d0 : m_d1) + PL;
                end
            end
            if (trig && !m_prev) det_q.push_back(cyc + 2);
            m_prev = trig;
        end
        exp_echo[0] = m_run && cyc >= m_start + 1 + m_d0 && cyc < m_start + 1 + m_d0 + PL;
        exp_echo[1] = m_run && cyc >= m_start + 1 + m_d1 && cyc < m_start + 1 + m_d1 + PL;
        #1;
        check("cyc_echo", echo, exp_echo);
        check("cyc_busy", busy, m_run);
        check("cyc_ovr", ovr, m_ovr);
    end

    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rise(output int e0);
        @(negedge clk);
        trig = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic set_trig(input logic v);
        @(negedge clk);
        trig = v;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    int e0, c;

    initial begin
        #1;
        check("rst_echo", echo, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic two-echo sequence; trigger held high must not retrigger
        @(negedge clk);
        en = 1'b1; d0 = 10; d1 = 25;
        rise(e0);
        at_edge(e0 + 1);  check("t1_busy_pre", busy, 0);
        at_edge(e0 + 2);  check("t1_busy_on", busy, 1);
        at_edge(e0 + 12); check("t1_e0_pre", echo, 2'b00);
        at_edge(e0 + 13); check("t1_e0_rise", echo, 2'b01);
        at_edge(e0 + 16); check("t1_e0_last", echo, 2'b01);
        at_edge(e0 + 17); check("t1_e0_fall", echo, 2'b00);
        at_edge(e0 + 28); check("t1_e1_rise", echo, 2'b10);
        at_edge(e0 + 31); check("t1_busy_last", busy, 1);
        at_edge(e0 + 32); check("t1_busy_off", busy, 0);
        check("t1_echo_off", echo, 2'b00);
        at_edge(e0 + 45); check("t1_held_busy", busy, 0);
        set_trig(1'b0);

        // Zero delays: coincident pulses
        @(negedge clk);
        d0 = 0; d1 = 0;
        rise(e0);
        at_edge(e0 + 3); check("t2_rise", echo, 2'b11);
        at_edge(e0 + 6); check("t2_last", echo, 2'b11);
        at_edge(e0 + 7); check("t2_fall", echo, 2'b00);
        check("t2_busy_off", busy, 0);
        set_trig(1'b0);
        repeat (4) @(negedge clk);

        // Trigger decided on the same edge RUN ends counts as overrun
        rise(e0);
        set_trig(1'b0);
        at_edge(e0 + 4);
        set_trig(1'b1);
        at_edge(e0 + 8);  check("t2b_ovr", ovr, 1);
        at_edge(e0 + 12); check("t2b_busy", busy, 0);
        set_trig(1'b0);
        repeat (4) @(negedge clk);

        // Overrun while busy; config change mid-run is ignored
        @(negedge clk);
        d0 = 100; d1 = 50;
        rise(e0);
        at_edge(e0 + 3);  set_trig(1'b0);
        at_edge(e0 + 10); @(negedge clk); d0 = 5; d1 = 7;
        at_edge(e0 + 19); set_trig(1'b1);
        at_edge(e0 + 25); check("t3_ovr", ovr, 2);
        set_trig(1'b0);
        at_edge(e0 + 102); check("t3_e0_pre", echo, 2'b00);
        at_edge(e0 + 103); check("t3_e0_rise", echo, 2'b01);
        at_edge(e0 + 106); check("t3_busy_last", busy, 1);
        at_edge(e0 + 107); check("t3_busy_off", busy, 0);

        // Disabled trigger is ignored without overrun
        @(negedge clk);
        en = 1'b0;
        rise(e0);
        at_edge(e0 + 6);
        check("t4_dis_busy", busy, 0);
        check("t4_dis_echo", echo, 2'b00);
        check("t4_dis_ovr", ovr, 2);
        set_trig(1'b0);

        // Enable dropped mid-run aborts at the next edge
        @(negedge clk);
        en = 1'b1; d0 = 20; d1 = 20;
        rise(e0);
        at_edge(e0 + 8); check("t4_busy_run", busy, 1);
        @(negedge clk); en = 1'b0;
        at_edge(e0 + 9);  check("t4_abort_busy", busy, 0);
        at_edge(e0 + 23); check("t4_abort_echo", echo, 2'b00);
        set_trig(1'b0);

        // Reset while echo is high
        @(negedge clk);
        en = 1'b1; d0 = 10; d1 = 30;
        rise(e0);
        at_edge(e0 + 2);  set_trig(1'b0);
        at_edge(e0 + 14); check("t5_echo_hi", echo, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_echo", echo, 2'b00);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ovr", ovr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = cyc;
        at_edge(c + 40);
        check("t5_post_echo", echo, 2'b00);
        check("t5_post_busy", busy, 0);

        // Trigger high across reset release is detected
        @(negedge clk);
        rst = 1'b1; trig = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = cyc + 1;
        at_edge(e0 + 1); check("t6_busy_pre", busy, 0);
        at_edge(e0 + 2); check("t6_busy_on", busy, 1);
        set_trig(1'b0);
        at_edge(e0 + 40); check("t6_busy_off", busy, 0);

        // Overrun saturation during a maximal-delay sequence
        @(negedge clk);
        d0 = 16'hFFFF; d1 = 0;
        rise(e0);
        at_edge(e0 + 3); set_trig(1'b0);
        for (int i = 0; i < 300; i++) begin
            set_trig(1'b1);
            set_trig(1'b0);
        end
        c = cyc;
        at_edge(c + 4); check("t7_ovr_sat", ovr, 255);
        at_edge(e0 + 2 + 65535); check("t7_e0_pre", echo, 2'b00);
        at_edge(e0 + 3 + 65535); check("t7_e0_rise", echo, 2'b01);
        at_edge(e0 + 6 + 65535); check("t7_e0_last", echo, 2'b01);
        at_edge(e0 + 7 + 65535);
        check("t7_e0_fall", echo, 2'b00);
        check("t7_busy_off", busy, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
